// File: rtl/coin_pkg.sv
// Shared types and default configuration for the coin change engine.
// Optional feature macro used by the engine: COIN_REFILL_EN (stack refill port).
package coin_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_SEL_DEN = 2'd1,
      ST_CALC    = 2'd2,
      ST_REPORT  = 2'd3
   } state_e;

   typedef enum logic [1:0] {
      STATUS_OK           = 2'b00,
      STATUS_BAD_NOTE     = 2'b01,
      STATUS_BAD_DEN      = 2'b10,
      STATUS_INSUFFICIENT = 2'b11
   } status_e;

   localparam int DEF_NUM_DEN    = 3;
   localparam int DEF_NUM_NOTES  = 5;
   localparam int DEF_CODE_W     = 3;
   localparam int DEF_VAL_W      = 12;
   localparam int DEF_CNT_W      = 9;
   localparam int DEF_STACK_W    = 11;
   localparam int DEF_INIT_COUNT = 500;

   // Coin values, index 0 (highest value) in the most significant byte
   localparam logic [DEF_NUM_DEN*8-1:0] DEF_DEN_VALUES = {8'd5, 8'd2, 8'd1};
   // Note values, code 0 in the most significant field
   localparam logic [DEF_NUM_NOTES*DEF_VAL_W-1:0] DEF_NOTE_VALUES =
      {12'd10, 12'd20, 12'd50, 12'd100, 12'd200};

   // Index width that stays legal for a single coin type
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/coin_stack_bank.sv
// Per-coin-type stack level registers: saturating refill and
// whole-bank commit of the shadow levels after a successful dispense.
module coin_stack_bank
   import coin_pkg::*;
#(
   parameter int NUM_DEN    = DEF_NUM_DEN,
   parameter int STACK_W    = DEF_STACK_W,
   parameter int INIT_COUNT = DEF_INIT_COUNT,
   parameter int IDX_W      = idx_width(DEF_NUM_DEN)
)(
   input  logic                       clk_in,
   input  logic                       rst_in,
   input  logic                       refill_en_in,
   input  logic [IDX_W-1:0]           refill_idx_in,
   input  logic [STACK_W-1:0]         refill_qty_in,
   input  logic                       commit_en_in,
   input  logic [NUM_DEN*STACK_W-1:0] commit_lvl_in,
   output logic [NUM_DEN*STACK_W-1:0] lvl_out
);

   logic [STACK_W-1:0] lvl_q [NUM_DEN];
   logic [STACK_W-1:0] lvl_d [NUM_DEN];
   logic [STACK_W:0]   sum   [NUM_DEN];

   for (genvar gi = 0; gi < NUM_DEN; gi++) begin : g_stack
      assign sum[gi] = {1'b0, lvl_q[gi]} + {1'b0, refill_qty_in};

      // Commit replaces the level; otherwise an addressed refill adds with saturation
      always_comb begin
         lvl_d[gi] = lvl_q[gi];
         if (commit_en_in) begin
            lvl_d[gi] = commit_lvl_in[gi*STACK_W +: STACK_W];
         end else if (refill_en_in && (refill_idx_in == IDX_W'(gi))) begin
            lvl_d[gi] = sum[gi][STACK_W] ? '1 : sum[gi][STACK_W-1:0];
         end
      end

      assign lvl_out[gi*STACK_W +: STACK_W] = lvl_q[gi];
   end

   // Stack level registers, refilled to the initial count on reset
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         for (int i = 0; i < NUM_DEN; i++) lvl_q[i] <= STACK_W'(INIT_COUNT);
      end else begin
         for (int i = 0; i < NUM_DEN; i++) lvl_q[i] <= lvl_d[i];
      end
   end

endmodule

// File: rtl/coin_change_engine.sv
// Greedy coin change engine: note -> denomination mask -> one coin type per
// cycle (highest value first) -> single-cycle report. Stacks are debited only
// when the whole amount can be paid. Define COIN_REFILL_EN to add refill ports.
module coin_change_engine
   import coin_pkg::*;
#(
   parameter int NUM_DEN    = DEF_NUM_DEN,
   parameter logic [NUM_DEN*8-1:0] DEN_VALUES = DEF_DEN_VALUES,
   parameter int NUM_NOTES  = DEF_NUM_NOTES,
   parameter int CODE_W     = DEF_CODE_W,
   parameter int VAL_W      = DEF_VAL_W,
   parameter logic [NUM_NOTES*VAL_W-1:0] NOTE_VALUES = DEF_NOTE_VALUES,
   parameter int CNT_W      = DEF_CNT_W,
   parameter int STACK_W    = DEF_STACK_W,
   parameter int INIT_COUNT = DEF_INIT_COUNT
)(
   input  logic                          clk_in,
   input  logic                          rst_in,
   input  logic                          note_valid_in,
   input  logic [CODE_W-1:0]             note_code_in,
   output logic                          note_ready_out,
   input  logic                          den_valid_in,
   input  logic [NUM_DEN-1:0]            den_mask_in,
   output logic                          sel_den_out,
   output logic                          busy_out,
   output logic                          done_out,
   output logic [1:0]                    status_out,
   output logic [NUM_DEN*CNT_W-1:0]      coins_out,
`ifdef COIN_REFILL_EN
   input  logic                          refill_valid_in,
   input  logic [idx_width(NUM_DEN)-1:0] refill_idx_in,
   input  logic [STACK_W-1:0]            refill_qty_in,
   output logic                          refill_ready_out,
`endif
   output logic [NUM_DEN*STACK_W-1:0]    stack_lvl_out
);

   localparam int IDX_W   = idx_width(NUM_DEN);
   localparam int NW      = (VAL_W > STACK_W) ? VAL_W : STACK_W;
   localparam int CNT_MAX = (1 << CNT_W) - 1;
   localparam logic [CODE_W:0] NOTES_LIM = (CODE_W+1)'(NUM_NOTES);

   state_e                     state_q, state_d;
   status_e                    pend_q, pend_d, status_q, status_d;
   logic [VAL_W-1:0]           rem_q, rem_d;
   logic [IDX_W-1:0]           idx_q, idx_d;
   logic [NUM_DEN-1:0]         mask_q, mask_d;
   logic [NUM_DEN*STACK_W-1:0] shadow_q, shadow_d;
   logic [NUM_DEN*CNT_W-1:0]   cnt_q, cnt_d, coins_q, coins_d;
   logic                       done_q, done_d, note_ready_q, note_ready_d;
   logic                       sel_den_q, sel_den_d, busy_q, busy_d;
   logic                       commit_en, refill_en;
   logic [IDX_W-1:0]           refill_idx;
   logic [STACK_W-1:0]         refill_qty;
   logic [NW-1:0]              n_all   [NUM_DEN];
   logic [VAL_W-1:0]           dec_all [NUM_DEN];

`ifdef COIN_REFILL_EN
   assign refill_en        = refill_valid_in && note_ready_q;
   assign refill_idx       = refill_idx_in;
   assign refill_qty       = refill_qty_in;
   assign refill_ready_out = note_ready_q;
`else
   assign refill_en  = 1'b0;
   assign refill_idx = '0;
   assign refill_qty = '0;
`endif

   coin_stack_bank #(
      .NUM_DEN    (NUM_DEN),
      .STACK_W    (STACK_W),
      .INIT_COUNT (INIT_COUNT),
      .IDX_W      (IDX_W)
   ) u_stack_bank (
      .clk_in        (clk_in),
      .rst_in        (rst_in),
      .refill_en_in  (refill_en),
      .refill_idx_in (refill_idx),
      .refill_qty_in (refill_qty),
      .commit_en_in  (commit_en),
      .commit_lvl_in (shadow_q),
      .lvl_out       (stack_lvl_out)
   );

   // Per coin type: coins to take n = min(rem/value, shadow stack, count limit)
   for (genvar gi = 0; gi < NUM_DEN; gi++) begin : g_den
      localparam logic [VAL_W-1:0] DEN_VAL = VAL_W'(DEN_VALUES[(NUM_DEN-1-gi)*8 +: 8]);
      logic [VAL_W-1:0] quot;
      logic [NW-1:0]    stk;
      logic [NW-1:0]    lim;
      assign quot        = rem_q / DEN_VAL;
      assign stk         = NW'(shadow_q[gi*STACK_W +: STACK_W]);
      assign lim         = (stk < NW'(CNT_MAX)) ? stk : NW'(CNT_MAX);
      assign n_all[gi]   = (NW'(quot) < lim) ? NW'(quot) : lim;
      assign dec_all[gi] = VAL_W'(n_all[gi]) * DEN_VAL;
   end

   // Next-state logic for the FSM and the greedy datapath
   always_comb begin
      state_d   = state_q;
      pend_d    = pend_q;
      status_d  = status_q;
      rem_d     = rem_q;
      idx_d     = idx_q;
      mask_d    = mask_q;
      shadow_d  = shadow_q;
      cnt_d     = cnt_q;
      coins_d   = coins_q;
      done_d    = 1'b0;
      commit_en = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (note_valid_in && note_ready_q) begin
               if ({1'b0, note_code_in} < NOTES_LIM) begin
                  for (int k = 0; k < NUM_NOTES; k++) begin
                     if ({1'b0, note_code_in} == (CODE_W+1)'(k))
                        rem_d = NOTE_VALUES[(NUM_NOTES-1-k)*VAL_W +: VAL_W];
                  end
                  state_d = ST_SEL_DEN;
               end else begin
                  pend_d  = STATUS_BAD_NOTE;
                  state_d = ST_REPORT;
               end
            end
         end
         ST_SEL_DEN: begin
            if (den_valid_in) begin
               if (den_mask_in == '0) begin
                  pend_d  = STATUS_BAD_DEN;
                  state_d = ST_REPORT;
               end else begin
                  mask_d   = den_mask_in;
                  idx_d    = '0;
                  shadow_d = stack_lvl_out;
                  state_d  = ST_CALC;
               end
            end
         end
         ST_CALC: begin
            for (int i = 0; i < NUM_DEN; i++) begin
               if (idx_q == IDX_W'(i)) begin
                  if (mask_q[i]) begin
                     rem_d = rem_q - dec_all[i];
                     shadow_d[i*STACK_W +: STACK_W] =
                        shadow_q[i*STACK_W +: STACK_W] - STACK_W'(n_all[i]);
                     cnt_d[i*CNT_W +: CNT_W] = CNT_W'(n_all[i]);
                  end else begin
                     cnt_d[i*CNT_W +: CNT_W] = '0;
                  end
               end
            end
            if (idx_q == IDX_W'(NUM_DEN-1)) begin
               pend_d  = (rem_d == '0) ? STATUS_OK : STATUS_INSUFFICIENT;
               state_d = ST_REPORT;
            end else begin
               idx_d = idx_q + 1'b1;
            end
         end
         ST_REPORT: begin
            done_d    = 1'b1;
            status_d  = pend_q;
            coins_d   = (pend_q == STATUS_OK) ? cnt_q : '0;
            commit_en = (pend_q == STATUS_OK);
            state_d   = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
      note_ready_d = (state_d == ST_IDLE);
      sel_den_d    = (state_d == ST_SEL_DEN);
      busy_d       = (state_d == ST_CALC);
   end

   // FSM state, datapath and registered outputs
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         state_q      <= ST_IDLE;
         pend_q       <= STATUS_OK;
         status_q     <= STATUS_OK;
         rem_q        <= '0;
         idx_q        <= '0;
         mask_q       <= '0;
         shadow_q     <= '0;
         cnt_q        <= '0;
         coins_q      <= '0;
         done_q       <= 1'b0;
         note_ready_q <= 1'b1;
         sel_den_q    <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         pend_q       <= pend_d;
         status_q     <= status_d;
         rem_q        <= rem_d;
         idx_q        <= idx_d;
         mask_q       <= mask_d;
         shadow_q     <= shadow_d;
         cnt_q        <= cnt_d;
         coins_q      <= coins_d;
         done_q       <= done_d;
         note_ready_q <= note_ready_d;
         sel_den_q    <= sel_den_d;
         busy_q       <= busy_d;
      end
   end

   assign note_ready_out = note_ready_q;
   assign sel_den_out    = sel_den_q;
   assign busy_out       = busy_q;
   assign done_out       = done_q;
   assign status_out     = status_q;
   assign coins_out      = coins_q;

endmodule

// File: tb/tb_coin_change_engine.sv
// Directed bench for coin_change_engine (default parameters).
// Refill checks are included when COIN_REFILL_EN is defined.
module tb_coin_change_engine;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        note_valid = 1'b0;
   logic [2:0]  note_code = '0;
   logic        note_ready;
   logic        den_valid = 1'b0;
   logic [2:0]  den_mask = '0;
   logic        sel_den, busy, done;
   logic [1:0]  status;
   logic [26:0] coins;
   logic [32:0] stacks;
`ifdef COIN_REFILL_EN
   logic        refill_valid = 1'b0;
   logic [1:0]  refill_idx = '0;
   logic [10:0] refill_qty = '0;
   logic        refill_ready;
`endif

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   coin_change_engine dut (
      .clk_in          (clk),
      .rst_in          (rst_n),
      .note_valid_in   (note_valid),
      .note_code_in    (note_code),
      .note_ready_out  (note_ready),
      .den_valid_in    (den_valid),
      .den_mask_in     (den_mask),
      .sel_den_out     (sel_den),
      .busy_out        (busy),
      .done_out        (done),
      .status_out      (status),
      .coins_out       (coins),
`ifdef COIN_REFILL_EN
      .refill_valid_in (refill_valid),
      .refill_idx_in   (refill_idx),
      .refill_qty_in   (refill_qty),
      .refill_ready_out(refill_ready),
`endif
      .stack_lvl_out   (stacks)
   );

   function automatic logic [63:0] co3(input logic [8:0] c0, input logic [8:0] c1, input logic [8:0] c2);
      return 64'({c2, c1, c0});
   endfunction

   function automatic logic [63:0] st3(input logic [10:0] s0, input logic [10:0] s1, input logic [10:0] s2);
      return 64'({s2, s1, s0});
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $display("FAIL %s observed=%0d required=%0d", tag, obs, exp);
         $error("check %s failed", tag);
      end
      $display("check %-14s observed=%0d required=%0d", tag, obs, exp);
   endtask

   // Count negedges until done_out, bounded
   task automatic wait_done(output int cyc);
      cyc = 0;
      while (done !== 1'b1 && cyc < 20) begin
         @(negedge clk);
         cyc++;
      end
   endtask

   // Full note + mask transaction with result checks
   task automatic txn(input string tag, input logic [2:0] code, input logic [2:0] mask,
                      input logic [1:0] exp_st, input logic [63:0] exp_coins,
                      input logic [63:0] exp_stacks);
      int cyc;
      @(negedge clk);
      note_valid = 1'b1; note_code = code;
      @(negedge clk);
      note_valid = 1'b0;
      check({tag, ".sel"}, 64'(sel_den), 64'd1);
      den_valid = 1'b1; den_mask = mask;
      @(negedge clk);
      den_valid = 1'b0; den_mask = '0;
      wait_done(cyc);
      check({tag, ".lat"}, 64'(cyc), 64'd4);
      check({tag, ".status"}, 64'(status), 64'(exp_st));
      check({tag, ".coins"}, 64'(coins), exp_coins);
      check({tag, ".stacks"}, 64'(stacks), exp_stacks);
   endtask

   initial begin
      int cyc;
      // Reset state
      #12;
      check("rst.ready", 64'(note_ready), 64'd1);
      check("rst.done", 64'(done), 64'd0);
      check("rst.busy", 64'(busy), 64'(0));
      check("rst.sel", 64'(sel_den), 64'd0);
      check("rst.status", 64'(status), 64'd0);
      check("rst.coins", 64'(coins), 64'd0);
      check("rst.stacks", 64'(stacks), st3(500, 500, 500));
      @(negedge clk);
      rst_n = 1'b1;

      // den_valid in IDLE is ignored
      @(negedge clk);
      den_valid = 1'b1; den_mask = 3'b111;
      @(negedge clk);
      den_valid = 1'b0;
      check("ign.sel", 64'(sel_den), 64'd0);
      check("ign.ready", 64'(note_ready), 64'd1);

      // 100 note, all types
      txn("t1", 3'd3, 3'b111, 2'b00, co3(20, 0, 0), st3(480, 500, 500));
      check("t1.busy", 64'(busy), 64'd0);
      @(negedge clk);
      check("t1.pulse", 64'(done), 64'd0);
      @(negedge clk);
      check("t1.hold", 64'(coins), co3(20, 0, 0));

      // 10 note, only 2-coins
      txn("t2", 3'd0, 3'b010, 2'b00, co3(0, 5, 0), st3(480, 495, 500));
      // Drain 2-coin stack with 200 notes
      txn("d1", 3'd4, 3'b010, 2'b00, co3(0, 100, 0), st3(480, 395, 500));
      txn("d2", 3'd4, 3'b010, 2'b00, co3(0, 100, 0), st3(480, 295, 500));
      txn("d3", 3'd4, 3'b010, 2'b00, co3(0, 100, 0), st3(480, 195, 500));
      txn("d4", 3'd4, 3'b010, 2'b00, co3(0, 100, 0), st3(480, 95, 500));
      // 95 available, 100 needed: nothing debited
      txn("t3", 3'd4, 3'b010, 2'b11, co3(0, 0, 0), st3(480, 95, 500));
      // 20 note with {5,2}: four 5-coins
      txn("t4", 3'd1, 3'b011, 2'b00, co3(4, 0, 0), st3(476, 95, 500));
      // 200 note with {2,1}: 2-stack capped at 95, rest in 1-coins
      txn("t5", 3'd4, 3'b110, 2'b00, co3(0, 95, 10), st3(476, 0, 490));
      // Empty 2-stack
      txn("t6", 3'd0, 3'b010, 2'b11, co3(0, 0, 0), st3(476, 0, 490));

      // Bad note codes: report one cycle after accept, SEL_DEN skipped
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         note_valid = 1'b1; note_code = (k == 0) ? 3'd7 : 3'd5;
         @(negedge clk);
         note_valid = 1'b0;
         check("bn.sel", 64'(sel_den), 64'd0);
         check("bn.early", 64'(done), 64'd0);
         @(negedge clk);
         check("bn.done", 64'(done), 64'd1);
         check("bn.status", 64'(status), 64'd1);
         check("bn.coins", 64'(coins), 64'd0);
      end

      // Empty mask: BAD_DEN one cycle after den accept
      @(negedge clk);
      note_valid = 1'b1; note_code = 3'd0;
      @(negedge clk);
      note_valid = 1'b0;
      den_valid = 1'b1; den_mask = 3'b000;
      @(negedge clk);
      den_valid = 1'b0;
      check("bd.busy", 64'(busy), 64'd0);
      wait_done(cyc);
      check("bd.lat", 64'(cyc), 64'd1);
      check("bd.status", 64'(status), 64'd2);
      check("bd.coins", 64'(coins), 64'd0);
      check("bd.stacks", 64'(stacks), st3(476, 0, 490));

      // Reset in the middle of CALC
      @(negedge clk);
      note_valid = 1'b1; note_code = 3'd3;
      @(negedge clk);
      note_valid = 1'b0;
      den_valid = 1'b1; den_mask = 3'b111;
      @(negedge clk);
      den_valid = 1'b0;
      @(negedge clk);
      check("mr.busy", 64'(busy), 64'd1);
      rst_n = 1'b0;
      #1;
      check("mr.ready", 64'(note_ready), 64'd1);
      check("mr.busyoff", 64'(busy), 64'd0);
      check("mr.done", 64'(done), 64'd0);
      check("mr.stacks", 64'(stacks), st3(500, 500, 500));
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("mr.nodone", 64'(done), 64'd0);
      txn("t7", 3'd2, 3'b100, 2'b00, co3(0, 0, 50), st3(500, 500, 450));

`ifdef COIN_REFILL_EN
      // Saturating refill
      @(negedge clk);
      check("rf.ready", 64'(refill_ready), 64'd1);
      refill_valid = 1'b1; refill_idx = 2'd2; refill_qty = 11'd2047;
      @(negedge clk);
      refill_valid = 1'b0;
      check("rf.sat", 64'(stacks), st3(500, 500, 2047));
      // Out-of-range index ignored
      refill_valid = 1'b1; refill_idx = 2'd3; refill_qty = 11'd5;
      @(negedge clk);
      refill_valid = 1'b0;
      check("rf.badidx", 64'(stacks), st3(500, 500, 2047));
      // Refill and note in the same IDLE cycle; refill held while busy is ignored
      note_valid = 1'b1; note_code = 3'd0;
      refill_valid = 1'b1; refill_idx = 2'd0; refill_qty = 11'd10;
      @(negedge clk);
      note_valid = 1'b0;
      refill_qty = 11'd7;
      check("rf.both", 64'(stacks), st3(510, 500, 2047));
      check("rf.selrdy", 64'(refill_ready), 64'd0);
      den_valid = 1'b1; den_mask = 3'b001;
      @(negedge clk);
      den_valid = 1'b0;
      check("rf.busyrdy", 64'(refill_ready), 64'd0);
      wait_done(cyc);
      refill_valid = 1'b0;
      check("rf.lat", 64'(cyc), 64'd4);
      check("rf.coins", 64'(coins), co3(2, 0, 0));
      check("rf.stacks", 64'(stacks), st3(508, 500, 2047));
      @(negedge clk);
      check("rf.after", 64'(stacks), st3(508, 500, 2047));
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
